// File: rtl/pu_pkg.sv
// rtl/pu_pkg.sv - shared defaults, FSM encoding and operand-slot constants for the PU feeder
package pu_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_PU_LAT    = 2;
  localparam int DEF_RES_DEPTH = 2;

  localparam int LANES = 4;
  localparam int SLOTS = 2 * LANES;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

endpackage

// File: rtl/pu_res_fifo.sv
// rtl/pu_res_fifo.sv - result FIFO; push and pop in one cycle keep the count and the order
module pu_res_fifo #(
  parameter int DATA_W    = 32,
  parameter int RES_DEPTH = 2,
  parameter int CW        = $clog2(RES_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count
);

  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [RES_DEPTH];
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_pop;
  logic              full;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (cnt_q != '0);
  assign full   = (cnt_q == CW'(RES_DEPTH));
  assign dout   = mem_q[rd_q];
  assign count  = cnt_q;

  // When full, the write slot equals the head slot, so a simultaneous pop frees it in time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      if (push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !do_pop && full));

endmodule

// File: rtl/pu_feeder.sv
// rtl/pu_feeder.sv - serial operand loader feeding a fixed-latency PU, with credit-limited issue
module pu_feeder import pu_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PU_LAT    = DEF_PU_LAT,
  parameter int RES_DEPTH = DEF_RES_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] a4,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic              issue,
  input  logic [DATA_W-1:0] pu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  localparam int WCNT_W = $clog2(SLOTS);
  localparam int CW     = $clog2(RES_DEPTH + 1);

  logic [0:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0] ops_q [SLOTS];
  logic [PU_LAT-1:0] vld_q, vld_d;
  logic [CW-1:0]     fifo_cnt;
  logic [31:0]       used;
  logic              accept;
  logic              push;
  logic              pop;

  assign in_ready = rst_n && (state_q == ST_LOAD);
  assign accept   = in_valid && in_ready;

  // Credit counts buffered plus in-flight results; a pop this cycle is not credited until next cycle.
  always_comb begin
    used = 32'(fifo_cnt);
    for (int i = 0; i < PU_LAT; i++) used = used + 32'(vld_q[i]);
  end

  assign issue = (state_q == ST_ISSUE) && (used < 32'(RES_DEPTH));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (accept) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == WCNT_W'(SLOTS - 1)) state_d = ST_ISSUE;
    end else if (issue) begin
      state_d = ST_LOAD;
    end
  end

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = issue;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      wcnt_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < SLOTS; i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      vld_q   <= vld_d;
      if (accept) ops_q[wcnt_q] <= in_data;
    end
  end

  assign push      = vld_q[PU_LAT-1];
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;
  assign busy      = (state_q != ST_LOAD) || (wcnt_q != '0) || (|vld_q) || res_valid;

  pu_res_fifo #(
    .DATA_W    (DATA_W),
    .RES_DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pu_out),
    .dout  (res_data),
    .count (fifo_cnt)
  );

  assign a1 = ops_q[0];
  assign a2 = ops_q[1];
  assign a3 = ops_q[2];
  assign a4 = ops_q[3];
  assign w1 = ops_q[4];
  assign w2 = ops_q[5];
  assign w3 = ops_q[6];
  assign w4 = ops_q[7];

endmodule
